iq_frame_capture: RTL
=====================

# iq_frame_capture

Parametrised capture stage for the time-multiplexed I/Q result stream produced by the VVM DSP down-converter/CIC chain. It deserialises one frame of `2*N_CH` words into a parallel register bank and validates the frame length, rejecting and flagging short or long frames. It also supports a freeze input so software can read a coherent snapshot, and keeps a committed-frame counter. It generalises the fixed grab-channels deserialiser to any channel count and word width, and adds error and snapshot behaviour.

## Interface
- `DW`, 21: signed word width of each I or Q sample.
- `N_CH`, 4: number of channels per frame; a frame is `2*N_CH` words.
- `CW`, 16: width of the committed-frame counter.

- `sample_clk`  in  1  sole clock; all logic on rising edge.
- `sample_rst`  in  1  reset, synchronous, active-high.
- `stream_in`  in  DW  serial words, order I0,Q0,I1,Q1,…,I(N_CH-1),Q(N_CH-1).
- `strobe_in`  in  1  high for every valid word of a frame; low between frames.
- `freeze`  in  1  when high, completed frames are not committed; outputs hold.
- `err_clr`  in  1  one-cycle pulse clears the sticky error flags.
- `iq_out`  out  2*N_CH*DW  committed frame; word j at `[j*DW +: DW]` (channel c: I at j=2c, Q at j=2c+1).
- `strobe_out`  out  1  one-cycle pulse when `iq_out` is updated.
- `frame_cnt`  out  CW  committed frames, wraps modulo 2^CW.
- `err_short`  out  1  sticky: a frame ended with fewer than `2*N_CH` words.
- `err_long`  out  1  sticky: strobe stayed high beyond `2*N_CH` words.

## Operation
- Internal shadow buffer of `2*N_CH` words plus word index `idx` (0..2*N_CH).
- States:
  - IDLE: waiting for `strobe_in`=1. On the first strobe cycle, write `stream_in` to shadow[0], set `idx`=1, go to RUN.
  - RUN, strobe high, `idx`<2*N_CH: write shadow[idx], increment `idx`.
  - RUN, strobe high, `idx`==2*N_CH: long frame. Set `err_long`, discard the frame, go to DRAIN.
  - RUN, strobe low, `idx`==2*N_CH: good frame. Commit, go to IDLE.
  - RUN, strobe low, `idx`<2*N_CH: short frame. Set `err_short`, discard, go to IDLE.
  - DRAIN: ignore words until `strobe_in`=0, then go to IDLE. No commit.
- Commit with `freeze`=0:
  - `iq_out` <= shadow.
  - `strobe_out` pulses for one cycle.
  - `frame_cnt` increments.
- Commit with `freeze`=1: the frame is dropped. No `strobe_out`, `iq_out` and `frame_cnt` unchanged, no error.
- `freeze` is sampled only in the commit cycle, so a frame already in flight when `freeze` rises is still decided by `freeze` at commit.
- Error flags are sticky. `err_clr` clears both. If an error event and `err_clr` occur in the same cycle, the flag ends set.
- Words are stored verbatim; no arithmetic or sign extension.

## Timing
- A frame's first word arrives at cycle t0 and its last word at t0+2N_CH-1; `strobe_in` is low at t0+2N_CH.
- `iq_out` updated and `strobe_out`=1 during cycle t0+2N_CH+1, i.e. one cycle after strobe falls.
- Minimum inter-frame gap: 1 low cycle. Back-to-back frames separated by exactly one low cycle must both commit.
- Long-frame flag: `err_long` is set in the cycle after the (2N_CH+1)-th strobe-high cycle.
- Short-frame flag: `err_short` is set in the cycle after strobe falls.
- Reset values:
  - `iq_out`=0, `strobe_out`=0, `frame_cnt`=0, `err_short`=0, `err_long`=0.
  - state=DRAIN; `idx`=0.
- Reset mid-frame: all state is cleared. After reset, state is DRAIN, so a frame already in progress is discarded silently with no error, and capture resumes at the next rising edge of strobe.
- `frame_cnt` wraps from 2^CW-1 to 0 with no flag.

## Test plan
- DW=21, N_CH=4, after reset and strobe low, one frame of words 1..8 -> one `strobe_out` pulse exactly 1 cycle after strobe falls; `iq_out` words = 1,2,…,8 (I0=1, Q3=8); `frame_cnt`=1.
- Three back-to-back frames with 1-cycle gaps, words 0x1FFFFF/0x100000 patterns -> 3 pulses, `frame_cnt`=3, each `iq_out` matches its frame; negative values preserved bit-exact.
- Frame of 5 words -> `err_short`=1, no `strobe_out`, `iq_out` unchanged; frame of 10 words -> `err_long`=1, no commit. `err_clr` pulse -> both 0; `err_clr` coincident with a new short frame end -> `err_short` stays 1.
- `freeze`=1 during two good frames -> no pulses, `iq_out` holds the last committed values, `frame_cnt` unchanged; `freeze`=0 -> the next frame commits normally.
- Assert `sample_rst` at word 3 of a frame while strobe stays high through word 8 -> outputs all 0, no error, no commit; the following clean frame commits with `frame_cnt`=1.
- CW=4, 17 good frames -> `frame_cnt` wraps to 1; also run with N_CH=1, DW=14 with a 2-word frame -> commit, and a 3-word frame -> `err_long`.

Source files
------------

// File: rtl/iq_frame_capture.sv
// iq_frame_capture: deserialises a 2*N_CH-word I/Q frame, validates its length and commits it to a parallel bank
module iq_frame_capture #(
    parameter int DW   = 21,
    parameter int N_CH = 4,
    parameter int CW   = 16
) (
    input  logic                   sample_clk,
    input  logic                   sample_rst,
    input  logic [DW-1:0]          stream_in,
    input  logic                   strobe_in,
    input  logic                   freeze,
    input  logic                   err_clr,
    output logic [2*N_CH*DW-1:0]   iq_out,
    output logic                   strobe_out,
    output logic [CW-1:0]          frame_cnt,
    output logic                   err_short,
    output logic                   err_long
);
    localparam int FW = 2 * N_CH;
    localparam int IW = $clog2(FW + 1);
    localparam logic [IW-1:0] LAST = IW'(FW);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [FW*DW-1:0]   shadow;

    // Frame FSM: fill the shadow bank, decide on strobe fall, commit or flag; errors set after clear so a coincident event wins
    always_ff @(posedge sample_clk) begin
        if (sample_rst) begin
            state      <= DRAIN;
            idx        <= '0;
            shadow     <= '0;
            iq_out     <= '0;
            strobe_out <= 1'b0;
            frame_cnt  <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            strobe_out <= 1'b0;
            if (err_clr) begin
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (strobe_in) begin
                        shadow[DW-1:0] <= stream_in;
                        idx            <= IW'(1);
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (strobe_in) begin
                        if (idx == LAST) begin
                            err_long <= 1'b1;
                            state    <= DRAIN;
                        end else begin
                            for (int j = 1; j < FW; j++)
                                if (idx == IW'(j)) shadow[j*DW +: DW] <= stream_in;
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        if (idx == LAST) begin
                            if (!freeze) begin
                                iq_out     <= shadow;
                                strobe_out <= 1'b1;
                                frame_cnt  <= frame_cnt + 1'b1;
                            end
                        end else begin
                            err_short <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!strobe_in) state <= IDLE;
                end
                default: state <= DRAIN;
            endcase
        end
    end
endmodule
